multi_sink: RTL and testbench
=============================

// Module: multi_sink
// PURPOSE
//  N-channel parametrised flit sink and traffic monitor for NoC ejection ports.
//  Each channel accepts flits over a req/busy handshake and applies programmable backpressure:
//  always-ready, always-busy, or pseudo-random with a set busy ratio.
//  Per-channel throughput is measured over a 2^SAMPLE_W-cycle window; misrouted flits are counted.
//  Sits at router local outputs in place of the single-channel sink, typically behind rx deserialisers.
// PARAMETERS
//  NCH       4    number of independent sink channels
//  ADDR_BITS 8    flit payload width (`ADDR_BITS); low ADDR_BITS carry destination address
//  SAMPLE_W  10   window length = 2^SAMPLE_W cycles
//  TP_W      12   per-channel throughput counter width (saturating)
//  ERR_W     16   misroute counter width (saturating)
// PORTS
//  clk        in   1              clock, all logic on posedge
//  reset      in   1              synchronous, active-high
//  req        in   NCH            per-channel flit valid
//  data       in   NCH*ADDR_BITS  channel c flit in data[c*ADDR_BITS +: ADDR_BITS]
//  busy       out  NCH            per-channel backpressure, registered
//  my_addr    in   ADDR_BITS      expected destination address of this node
//  bp_mode    in   2              0 ready, 1 always busy, 2 random, 3 reserved (= ready)
//  bp_thresh  in   8              random mode: busy when lfsr[7:0] < bp_thresh
//  throughput out  NCH*TP_W       last completed window count, channel c at [c*TP_W +: TP_W]
//  tp_valid   out  1              one-cycle pulse when throughput updates
//  err_count  out  ERR_W          accepted flits with data != my_addr, all channels
//  total_flits out 32             accepted flits since reset, all channels, wraps
// BEHAVIOUR
//  Reset (synchronous, one clk with reset=1): busy=all 1, throughput=0, tp_valid=0, err_count=0,
//   total_flits=0, window=0, running counts=0; LFSR c seeded to 8'hA5 ^ c (never zero).
//  Accept: flit on channel c accepted in cycle t iff req[c]=1 and busy[c]=0 in cycle t.
//   req while busy is ignored (sender holds); no buffering, zero latency.
//  busy[c] next = (bp_mode==1) | (bp_mode==2 & lfsr_c[7:0] < bp_thresh); computed every cycle.
//   First cycle after reset release busy reflects mode; bp_thresh=0 in mode 2 -> never busy.
//   bp_thresh=255 -> busy 255/256 of cycles. Mode changes take effect next cycle.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle, per channel.
//  Window: SAMPLE_W-bit counter increments every cycle. At all-ones (terminal) cycle:
//   throughput[c] <= running[c] + accept[c] (terminal-cycle flit IS counted), running <= 0,
//   tp_valid <= 1 next cycle for exactly one cycle. Else running[c] += accept[c].
//   Running/throughput saturate at 2^TP_W-1 (legal when TP_W < SAMPLE_W+1).
//  Misroute: per accepted flit with data != my_addr, err_count += 1; multiple channels in
//   one cycle add popcount; saturates at 2^ERR_W-1.
//  total_flits += popcount(accept) each cycle, modulo 2^32.
//  Reset mid-window discards partial counts; throughput returns to 0.
//  Each accepted flit $display'd with channel index and data (sim only, translate_off).
// STRUCTURE
//  Package sink_pkg: BP_READY=2'd0, BP_BUSY=2'd1, BP_RAND=2'd2, LFSR_SEED=16'h00A5, LFSR_TAPS.
//  Sub-module sink_lfsr (clk, reset, seed, state[15:0]); one per channel via generate.
//  Top: window counter, per-channel running/throughput regs, popcount adders, sat logic.
// TESTING
//  1 mode 0, req=all 1 continuously, SAMPLE_W=4 -> busy=0 from cycle 1; each throughput=16
//    after first full window, tp_valid single pulse every 16 cycles; total_flits = 16*NCH*windows.
//  2 mode 1, req=all 1 -> no accepts; throughput=0, err_count=0, total_flits=0.
//  3 mode 2, bp_thresh=128, 4096 cycles -> each channel accept ratio 0.5 +/- 0.05; channels
//    differ (distinct seeds); never accept when busy=1 (assertion).
//  4 my_addr=5, ch0 sends 5, ch1 sends 7, both every cycle, mode 0 -> err_count += 1/cycle;
//    ch2+ch3 both misroute same cycle -> +2; ERR_W=4 saturates at 15.
//  5 single flit on ch0 exactly at terminal window cycle -> next throughput[0]=1, following
//    window 0; TP_W=3 with 16 flits/window -> throughput saturates at 7.
//  6 reset asserted mid-window with running=9 -> throughput=0, busy=all 1 during reset,
//    next window counts from zero; LFSR sequence restarts identically.

Source files
------------

// File: rtl/multi_sink_pkg.sv
// -----------------------------------------------------------------------------
// multi_sink_pkg
//   Shared definitions for the multi-channel flit sink: backpressure mode
//   encoding, LFSR seed/taps and the LFSR next-state function.
// -----------------------------------------------------------------------------
package multi_sink_pkg;

  // Backpressure mode; the reserved encoding behaves like BP_READY.
  typedef enum logic [1:0] {
    BP_READY = 2'd0,
    BP_BUSY  = 2'd1,
    BP_RAND  = 2'd2,
    BP_RSVD  = 2'd3
  } bp_mode_e;

  // Channel c is seeded with LFSR_SEED ^ c so every channel runs a distinct,
  // non-zero sequence.
  localparam logic [15:0] LFSR_SEED = 16'h00A5;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/multi_sink_if.sv
// -----------------------------------------------------------------------------
// multi_sink_if
//   Flit ejection bundle for NCH channels.
//   req  : per-channel flit valid (sender -> sink)
//   data : channel c flit in data[c*ADDR_BITS +: ADDR_BITS] (sender -> sink)
//   busy : per-channel backpressure (sink -> sender); a flit moves in any
//          cycle with req=1 and busy=0.
// -----------------------------------------------------------------------------
interface multi_sink_if #(
  parameter int NCH       = 4,
  parameter int ADDR_BITS = 8
);

  logic [NCH-1:0]           req;
  logic [NCH*ADDR_BITS-1:0] data;
  logic [NCH-1:0]           busy;

  modport master (output req, output data, input busy);
  modport slave  (input req, input data, output busy);

endinterface

// File: rtl/multi_sink_lfsr.sv
// -----------------------------------------------------------------------------
// multi_sink_lfsr
//   16-bit Galois LFSR advancing every cycle; loaded with seed during reset.
//   clk   : clock
//   reset : synchronous, active-high; loads seed
//   seed  : reset value (must be non-zero)
//   state : current LFSR state
// -----------------------------------------------------------------------------
module multi_sink_lfsr
  import multi_sink_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (reset) state <= seed;
    else       state <= lfsr_next(state);
  end

endmodule

// File: rtl/multi_sink.sv
// -----------------------------------------------------------------------------
// multi_sink
//   NCH-channel flit sink and traffic monitor for NoC ejection ports.
//   Each channel applies programmable backpressure (ready / busy / random),
//   counts accepted flits per 2^SAMPLE_W-cycle window and flags misroutes.
//
//   clk         : clock
//   reset       : synchronous, active-high
//   flit        : req/data in, busy out (registered), one lane per channel
//   my_addr     : destination address expected on every flit
//   bp_mode     : 0 ready, 1 always busy, 2 random, 3 treated as ready
//   bp_thresh   : random mode busy when lfsr[7:0] < bp_thresh
//   throughput  : last completed window count, channel c at [c*TP_W +: TP_W]
//   tp_valid    : one-cycle pulse when throughput is refreshed
//   err_count   : saturating count of accepted flits with data != my_addr
//   total_flits : accepted flits since reset, all channels, wraps at 2^32
// -----------------------------------------------------------------------------
module multi_sink
  import multi_sink_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int ADDR_BITS = 8,
  parameter int SAMPLE_W  = 10,
  parameter int TP_W      = 12,
  parameter int ERR_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_sink_if.slave          flit,
  input  logic [ADDR_BITS-1:0] my_addr,
  input  logic [1:0]           bp_mode,
  input  logic [7:0]           bp_thresh,
  output logic [NCH*TP_W-1:0]  throughput,
  output logic                 tp_valid,
  output logic [ERR_W-1:0]     err_count,
  output logic [31:0]          total_flits
);

  localparam int CNT_W = $clog2(NCH + 1);

  bp_mode_e            mode;
  logic [SAMPLE_W-1:0] win_q;
  logic                terminal;
  logic [NCH-1:0]      busy_q;
  logic [NCH-1:0]      busy_next;
  logic [NCH-1:0]      accept;
  logic [NCH-1:0]      misroute;
  logic [CNT_W-1:0]    n_acc;
  logic [CNT_W-1:0]    n_err;
  logic [ERR_W:0]      err_sum;
  logic [ERR_W-1:0]    err_next;

  assign mode      = bp_mode_e'(bp_mode);
  assign terminal  = &win_q;
  assign flit.busy = busy_q;

  // ---------------------------------------------------------------------------
  // Per-channel handshake, backpressure and window counting
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [15:0]     lfsr_state;
    logic [TP_W:0]   run_sum;
    logic [TP_W-1:0] run_sat;
    logic [TP_W-1:0] run_q;
    logic [TP_W-1:0] tp_q;

    multi_sink_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED ^ 16'(c)),
      .state (lfsr_state)
    );

    assign accept[c]   = flit.req[c] & ~busy_q[c];
    assign misroute[c] = accept[c] & (flit.data[c*ADDR_BITS +: ADDR_BITS] != my_addr);

    // Only the low byte of the LFSR sets the random busy ratio.
    assign busy_next[c] = (mode == BP_BUSY) |
                          ((mode == BP_RAND) &
                           ((lfsr_state & 16'h00FF) < {8'h00, bp_thresh}));

    assign run_sum = {1'b0, run_q} + {{TP_W{1'b0}}, accept[c]};
    assign run_sat = run_sum[TP_W] ? {TP_W{1'b1}} : run_sum[TP_W-1:0];

    // A flit accepted on the terminal cycle belongs to the closing window.
    always_ff @(posedge clk) begin
      if (reset) begin
        run_q <= '0;
        tp_q  <= '0;
      end else if (terminal) begin
        tp_q  <= run_sat;
        run_q <= '0;
      end else begin
        run_q <= run_sat;
      end
    end

    assign throughput[c*TP_W +: TP_W] = tp_q;
  end

  // ---------------------------------------------------------------------------
  // Aggregate counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    err_next = err_count;
    n_acc    = CNT_W'($countones(accept));
    n_err    = CNT_W'($countones(misroute));
    err_sum  = {1'b0, err_count} + (ERR_W+1)'(n_err);
    if (err_sum[ERR_W]) err_next = '1;
    else                err_next = err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '1;
      win_q       <= '0;
      tp_valid    <= 1'b0;
      err_count   <= '0;
      total_flits <= '0;
    end else begin
      busy_q      <= busy_next;
      win_q       <= win_q + SAMPLE_W'(1);
      tp_valid    <= terminal;
      err_count   <= err_next;
      total_flits <= total_flits + 32'(n_acc);
    end
  end

endmodule

// File: tb/tb_multi_sink.sv
// -----------------------------------------------------------------------------
// tb_multi_sink
//   Two sinks share one stimulus: dut_a with wide counters and dut_b with
//   TP_W=3 / ERR_W=4 to exercise saturation. A cycle model predicts busy,
//   counters and window results; window results go through a scoreboard queue
//   and are popped when the sink pulses tp_valid.
// -----------------------------------------------------------------------------
module tb_multi_sink;

  localparam int NCH    = 4;
  localparam int AB     = 8;
  localparam int SW     = 4;
  localparam int TPW_A  = 12;
  localparam int ERRW_A = 16;
  localparam int TPW_B  = 3;
  localparam int ERRW_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NCH-1:0]       req;
  logic [NCH*AB-1:0]    data;
  logic [AB-1:0]        my_addr;
  logic [1:0]           bp_mode;
  logic [7:0]           bp_thresh;
  logic [NCH*TPW_A-1:0] tp_a;
  logic [NCH*TPW_B-1:0] tp_b;
  logic                 tpv_a, tpv_b;
  logic [ERRW_A-1:0]    err_a;
  logic [ERRW_B-1:0]    err_b;
  logic [31:0]          tot_a, tot_b;

  multi_sink_if #(.NCH(NCH), .ADDR_BITS(AB)) bus_a ();
  multi_sink_if #(.NCH(NCH), .ADDR_BITS(AB)) bus_b ();

  assign bus_a.req  = req;
  assign bus_a.data = data;
  assign bus_b.req  = req;
  assign bus_b.data = data;

  multi_sink #(.NCH(NCH), .ADDR_BITS(AB), .SAMPLE_W(SW), .TP_W(TPW_A), .ERR_W(ERRW_A)) dut_a (
    .clk(clk), .reset(reset), .flit(bus_a), .my_addr(my_addr), .bp_mode(bp_mode),
    .bp_thresh(bp_thresh), .throughput(tp_a), .tp_valid(tpv_a), .err_count(err_a),
    .total_flits(tot_a)
  );

  multi_sink #(.NCH(NCH), .ADDR_BITS(AB), .SAMPLE_W(SW), .TP_W(TPW_B), .ERR_W(ERRW_B)) dut_b (
    .clk(clk), .reset(reset), .flit(bus_b), .my_addr(my_addr), .bp_mode(bp_mode),
    .bp_thresh(bp_thresh), .throughput(tp_b), .tp_valid(tpv_b), .err_count(err_b),
    .total_flits(tot_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    int a [NCH];
    int b [NCH];
  } tp_exp_t;

  logic [15:0]    m_lfsr [NCH];
  logic [NCH-1:0] m_busy;
  logic [SW-1:0]  m_win;
  int             m_run_a [NCH];
  int             m_run_b [NCH];
  logic           m_tpv;
  int             m_err_a, m_err_b;
  logic [31:0]    m_total;
  tp_exp_t        sb_q [$];
  int             obs_acc [NCH];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock: advance the model on the current inputs, clock, then compare.
  task automatic step();
    logic [NCH-1:0] acc;
    logic [NCH-1:0] nb;
    int             n_acc, n_err;
    tp_exp_t        e;

    for (int c = 0; c < NCH; c++)
      if (req[c] && !bus_a.busy[c]) obs_acc[c]++;

    if (reset) begin
      m_busy  = '1;
      m_win   = '0;
      m_tpv   = 1'b0;
      m_err_a = 0;
      m_err_b = 0;
      m_total = '0;
      for (int c = 0; c < NCH; c++) begin
        m_lfsr[c]  = 16'h00A5 ^ 16'(c);
        m_run_a[c] = 0;
        m_run_b[c] = 0;
      end
      sb_q.delete();
    end else begin
      acc   = req & ~m_busy;
      n_acc = 0;
      n_err = 0;
      for (int c = 0; c < NCH; c++) begin
        nb[c] = (bp_mode == 2'd1) || (bp_mode == 2'd2 && m_lfsr[c][7:0] < bp_thresh);
        m_lfsr[c] = {1'b0, m_lfsr[c][15:1]} ^ (m_lfsr[c][0] ? 16'hB400 : 16'h0000);
        if (acc[c]) begin
          n_acc++;
          if (data[c*AB +: AB] != my_addr) n_err++;
        end
      end
      m_err_a = sat(m_err_a + n_err, (1 << ERRW_A) - 1);
      m_err_b = sat(m_err_b + n_err, (1 << ERRW_B) - 1);
      m_total = m_total + 32'(n_acc);
      if (m_win == '1) begin
        for (int c = 0; c < NCH; c++) begin
          e.a[c]     = sat(m_run_a[c] + int'(acc[c]), (1 << TPW_A) - 1);
          e.b[c]     = sat(m_run_b[c] + int'(acc[c]), (1 << TPW_B) - 1);
          m_run_a[c] = 0;
          m_run_b[c] = 0;
        end
        sb_q.push_back(e);
        m_tpv = 1'b1;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          m_run_a[c] = sat(m_run_a[c] + int'(acc[c]), (1 << TPW_A) - 1);
          m_run_b[c] = sat(m_run_b[c] + int'(acc[c]), (1 << TPW_B) - 1);
        end
        m_tpv = 1'b0;
      end
      m_win++;
      m_busy = nb;
    end

    @(posedge clk);
    #1;

    checks++;
    if (bus_a.busy !== m_busy || bus_b.busy !== m_busy) begin
      errors++;
      $display("FAIL busy t=%0t got a=%b b=%b want %b", $time, bus_a.busy, bus_b.busy, m_busy);
    end
    checks++;
    if (tpv_a !== m_tpv || tpv_b !== m_tpv) begin
      errors++;
      $display("FAIL tp_valid t=%0t got a=%b b=%b want %b", $time, tpv_a, tpv_b, m_tpv);
    end
    if (tpv_a === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tp_unexpected t=%0t got pulse want none", $time);
      end else begin
        e = sb_q.pop_front();
        for (int c = 0; c < NCH; c++) begin
          checks++;
          if (tp_a[c*TPW_A +: TPW_A] !== TPW_A'(e.a[c]) || tp_b[c*TPW_B +: TPW_B] !== TPW_B'(e.b[c])) begin
            errors++;
            $display("FAIL throughput ch%0d t=%0t got a=%0d b=%0d want a=%0d b=%0d", c, $time,
                     tp_a[c*TPW_A +: TPW_A], tp_b[c*TPW_B +: TPW_B], e.a[c], e.b[c]);
          end
        end
      end
    end
    checks++;
    if (err_a !== ERRW_A'(m_err_a) || err_b !== ERRW_B'(m_err_b)) begin
      errors++;
      $display("FAIL err_count t=%0t got a=%0d b=%0d want a=%0d b=%0d", $time, err_a, err_b, m_err_a, m_err_b);
    end
    checks++;
    if (tot_a !== m_total || tot_b !== m_total) begin
      errors++;
      $display("FAIL total_flits t=%0t got a=%0d b=%0d want %0d", $time, tot_a, tot_b, m_total);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Steps until the model window sits on its terminal cycle (bounded).
  task automatic wait_terminal();
    int n;
    n = 0;
    while (m_win != '1 && n < 64) begin
      step();
      n++;
    end
    checks++;
    if (m_win != '1) begin
      errors++;
      $display("FAIL wait_terminal got win=%0d want terminal", m_win);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus_a.busy !== 4'hF || tp_a !== '0 || tpv_a !== 1'b0 || err_a !== '0 || tot_a !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b tp=%h tpv=%b err=%0d tot=%0d", bus_a.busy, tp_a, tpv_a, err_a, tot_a);
    end
    reset = 1'b0;
  endtask

  task automatic test_ready_stream();
    int pulses;
    do_reset();
    bp_mode = 2'd0;
    req     = '1;
    data    = {NCH{8'd5}};
    step();
    checks++;
    if (bus_a.busy !== 4'h0) begin
      errors++;
      $display("FAIL ready_busy got %b want 0000", bus_a.busy);
    end
    pulses = 0;
    for (int i = 0; i < 47; i++) begin
      step();
      if (tpv_a === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL ready_pulses got %0d want 3", pulses);
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (tp_a[c*TPW_A +: TPW_A] !== 12'd16 || tp_b[c*TPW_B +: TPW_B] !== 3'd7) begin
        errors++;
        $display("FAIL ready_tp ch%0d got a=%0d b=%0d want a=16 b=7", c,
                 tp_a[c*TPW_A +: TPW_A], tp_b[c*TPW_B +: TPW_B]);
      end
    end
    checks++;
    if (tot_a !== 32'(47 * NCH)) begin
      errors++;
      $display("FAIL ready_total got %0d want %0d", tot_a, 47 * NCH);
    end
  endtask

  task automatic test_always_busy();
    do_reset();
    bp_mode = 2'd1;
    req     = '1;
    data    = {NCH{8'd7}};
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (tot_a !== 32'd0 || err_a !== '0 || tp_a !== '0 || bus_a.busy !== 4'hF) begin
      errors++;
      $display("FAIL busy_mode got tot=%0d err=%0d tp=%h busy=%b want 0 0 0 1111", tot_a, err_a, tp_a, bus_a.busy);
    end
  endtask

  task automatic test_random();
    int diff;
    do_reset();
    bp_mode   = 2'd2;
    bp_thresh = 8'd128;
    req       = '1;
    data      = {NCH{8'd5}};
    diff      = 0;
    for (int c = 0; c < NCH; c++) obs_acc[c] = 0;
    for (int i = 0; i < 4096; i++) begin
      step();
      if (bus_a.busy[0] != bus_a.busy[1]) diff++;
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (obs_acc[c] < 1843 || obs_acc[c] > 2253) begin
        errors++;
        $display("FAIL random_ratio ch%0d got %0d want 1843..2253", c, obs_acc[c]);
      end
    end
    checks++;
    if (diff == 0) begin
      errors++;
      $display("FAIL random_distinct got identical ch0/ch1 busy want differing");
    end
    bp_thresh = 8'd0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (bus_a.busy !== 4'h0) begin
      errors++;
      $display("FAIL thresh0 got %b want 0000", bus_a.busy);
    end
    bp_thresh = 8'd255;
    for (int i = 0; i < 64; i++) step();
    bp_mode = 2'd3;
    step();
    checks++;
    if (bus_a.busy !== 4'h0) begin
      errors++;
      $display("FAIL mode3 got %b want 0000", bus_a.busy);
    end
  endtask

  task automatic test_misroute();
    logic [ERRW_A-1:0] e0;
    do_reset();
    bp_mode = 2'd0;
    my_addr = 8'd5;
    data    = {8'd9, 8'd9, 8'd7, 8'd5};
    req     = 4'b0011;
    step();
    e0 = err_a;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (err_a - e0 !== 16'd10) begin
      errors++;
      $display("FAIL misroute_single got +%0d want +10", err_a - e0);
    end
    req = 4'b1100;
    e0  = err_a;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (err_a - e0 !== 16'd10) begin
      errors++;
      $display("FAIL misroute_pair got +%0d want +10", err_a - e0);
    end
    checks++;
    if (err_b !== 4'd15) begin
      errors++;
      $display("FAIL misroute_sat got %0d want 15", err_b);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_terminal_flit();
    do_reset();
    bp_mode = 2'd0;
    req     = '0;
    data    = {NCH{8'd5}};
    step();
    wait_terminal();
    req = 4'b0001;
    step();
    req = '0;
    checks++;
    if (tpv_a !== 1'b1 || tp_a[0 +: TPW_A] !== 12'd1) begin
      errors++;
      $display("FAIL terminal_flit got tpv=%b tp0=%0d want 1 1", tpv_a, tp_a[0 +: TPW_A]);
    end
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (tpv_a !== 1'b1 || tp_a[0 +: TPW_A] !== 12'd0) begin
      errors++;
      $display("FAIL terminal_next got tpv=%b tp0=%0d want 1 0", tpv_a, tp_a[0 +: TPW_A]);
    end
  endtask

  task automatic test_reset_mid_window();
    int n;
    do_reset();
    bp_mode = 2'd0;
    req     = '1;
    data    = {NCH{8'd5}};
    step();
    wait_terminal();
    step();
    n = 0;
    while (m_run_a[0] != 9 && n < 32) begin
      step();
      n++;
    end
    checks++;
    if (m_run_a[0] != 9) begin
      errors++;
      $display("FAIL mid_setup got run=%0d want 9", m_run_a[0]);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus_a.busy !== 4'hF || tp_a !== '0 || tp_b !== '0 || tot_a !== '0 || err_a !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b tpa=%h tpb=%h tot=%0d err=%0d want all-busy, zeros",
               bus_a.busy, tp_a, tp_b, tot_a, err_a);
    end
    reset     = 1'b0;
    bp_mode   = 2'd2;
    bp_thresh = 8'd128;
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (tpv_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_window got tpv=%b want 1 after 16 cycles", tpv_a);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    data      = '0;
    my_addr   = 8'd5;
    bp_mode   = 2'd0;
    bp_thresh = 8'd0;
    for (int c = 0; c < NCH; c++) obs_acc[c] = 0;

    test_reset();
    test_ready_stream();
    test_always_busy();
    test_random();
    test_misroute();
    test_terminal_flit();
    test_reset_mid_window();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
